// File: rtl/exp_ci_pkg.sv
// Shared types and IEEE-754 constants for the exp custom-instruction controller.
package exp_ci_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned CNT_W  = 6;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/exp_ci_special.sv
// Combinational classifier of IEEE-754 single operands whose exp() is known
// without the pipeline. Used only when EXP_CI_SPECIAL_BYPASS_EN is defined.
module exp_ci_special
    import exp_ci_pkg::*;
(
    input  logic [31:0] operand_i,
    output logic        is_special_o,
    output logic [31:0] special_val_o
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;
    logic              sign_f;

    assign sign_f = operand_i[31];
    assign exp_f  = operand_i[30:MANT_W];
    assign mant_f = operand_i[MANT_W-1:0];

    always_comb begin
        is_special_o  = 1'b0;
        special_val_o = FP_ZERO;
        if (exp_f == '1) begin
            is_special_o = 1'b1;
            if (mant_f != '0) begin
                special_val_o = FP_QNAN;
            end else if (sign_f) begin
                special_val_o = FP_ZERO;
            end else begin
                special_val_o = FP_PINF;
            end
        end else if (exp_f == '0 && mant_f == '0) begin
            is_special_o  = 1'b1;
            special_val_o = FP_ONE;
        end
    end

endmodule

// File: rtl/exp_ci_ctrl.sv
// Multicycle Nios II CI controller for the single-precision exp pipeline.
// Define EXP_CI_SPECIAL_BYPASS_EN to short-circuit NaN/inf/zero operands.
module exp_ci_ctrl
    import exp_ci_pkg::*;
#(
    parameter int unsigned LATENCY = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic [31:0] core_data,
    input  logic [31:0] core_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic [31:0]        core_data_q, core_data_d;

`ifdef EXP_CI_SPECIAL_BYPASS_EN
    logic        is_special;
    logic [31:0] special_val;

    exp_ci_special u_special (
        .operand_i     (dataa),
        .is_special_o  (is_special),
        .special_val_o (special_val)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            core_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            core_data_q <= core_data_d;
        end
    end

    // The operand stays on core_data for the whole operation: the pipeline
    // has no enable, so a held input keeps core_result valid across stalls.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        core_data_d = core_data_q;
        if (clk_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        core_data_d = dataa;
                        cnt_d       = '0;
                        state_d     = BUSY;
`ifdef EXP_CI_SPECIAL_BYPASS_EN
                        if (is_special) begin
                            result_d = special_val;
                            state_d  = DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = core_result;
                        state_d  = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        done      = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = result_q;
        core_data = core_data_q;
    end

endmodule

// File: tb/tb_exp_ci_ctrl.sv
// Scoreboard bench for exp_ci_ctrl with a fixed-latency exp pipeline model.
// Expectations follow EXP_CI_SPECIAL_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_exp_ci_ctrl;

    localparam int unsigned LAT = 17;
`ifdef EXP_CI_SPECIAL_BYPASS_EN
    localparam int unsigned BYP_EDGES = 0;
    localparam logic [31:0] NAN_RES   = 32'h7FC0_0000;
`else
    localparam int unsigned BYP_EDGES = LAT + 1;
    localparam logic [31:0] NAN_RES   = 32'hDEAD_BEEF;
`endif

    logic        clk = 1'b0;
    logic        reset, clk_en, start, done, busy;
    logic [31:0] dataa, result, core_data, core_result;

    always #5 clk = ~clk;

    exp_ci_ctrl #(.LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .start       (start),
        .dataa       (dataa),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .core_data   (core_data),
        .core_result (core_result)
    );

    function automatic logic [31:0] model(input logic [31:0] x);
        case (x)
            32'h3F80_0000: model = 32'h402D_F854;
            32'h4000_0000: model = 32'h40EC_7326;
            32'hFF80_0000: model = 32'h0000_0000;
            32'h8000_0000: model = 32'h3F80_0000;
            32'h7F80_0000: model = 32'h7F80_0000;
            default:       model = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Free-running pipeline: no clock enable, like the real core.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= model(core_data);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_result = pipe[LAT-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] val;
        int unsigned done_cyc;
        string       name;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'h0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, result, e.val);
                check({e.name, "_done_cycle"}, cyc, e.done_cyc);
                check({e.name, "_busy_at_done"}, {31'b0, busy}, 32'h1);
            end
        end
    end

    // edges: number of clock edges from the start-sampling edge to the
    // edge that captures result.
    task automatic issue(input string name, input logic [31:0] a, input int unsigned edges,
                         input logic [31:0] val, input bit push);
        @(negedge clk);
        start = 1'b1;
        dataa = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sbq.push_back('{val: val, done_cyc: cyc + edges, name: name});
        check({name, "_core_data"}, core_data, a);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && busy === 1'b0) return;
        end
        checks++;
        $display("FAIL %s_timeout: pending %0d busy %b expected 0 pending, busy 0", name, sbq.size(), busy);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_core_data", core_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Nominal
        issue("nominal", 32'h3F80_0000, LAT + 1, 32'h402D_F854, 1'b1);
        check("nominal_busy", {31'b0, busy}, 32'h1);
        drain("nominal");

        // Stall of 3 cycles at count 5
        issue("stall", 32'h3F80_0000, LAT + 4, 32'h402D_F854, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        drain("stall");

        // Second start at count 8 must be ignored
        issue("ign", 32'h3F80_0000, LAT + 1, 32'h402D_F854, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        dataa = 32'h4000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_core_data_held", core_data, 32'h3F80_0000);
        drain("ign");

        // Special operands
        issue("ninf", 32'hFF80_0000, BYP_EDGES, 32'h0000_0000, 1'b1);
        drain("ninf");
        issue("nzero", 32'h8000_0000, BYP_EDGES, 32'h3F80_0000, 1'b1);
        drain("nzero");
        issue("pinf", 32'h7F80_0000, BYP_EDGES, 32'h7F80_0000, 1'b1);
        drain("pinf");
        issue("nan", 32'h7FC0_0001, BYP_EDGES, NAN_RES, 1'b1);
        drain("nan");
        issue("two", 32'h4000_0000, LAT + 1, 32'h40EC_7326, 1'b1);
        drain("two");

        // Reset at count 5: no done, result cleared
        issue("rstmid", 32'h3F80_0000, 0, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_result", result, 32'h0);
        check("rstmid_busy", {31'b0, busy}, 32'h0);
        check("rstmid_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 10) @(negedge clk);
        issue("after_rst", 32'h3F80_0000, LAT + 1, 32'h402D_F854, 1'b1);
        drain("after_rst");

        // start and reset together: reset wins
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        dataa = 32'h4000_0000;
        @(posedge clk);
        #1;
        check("rst_start_busy", {31'b0, busy}, 32'h0);
        check("rst_start_core_data", core_data, 32'h0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (LAT + 4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
